stereo_window_buff: RTL

Line-buffer sliding-window generator for the stereo SGM datapath. It accepts CH pixel streams in lock-step, one pixel per channel per accepted cycle, in raster order. For each accepted pixel it presents the WINDOW_H×WINDOW_W neighbourhood ending at that pixel. Frame geometry is tracked with column/row counters, so only windows lying fully inside the frame are flagged valid. It replaces the flat full-frame shift register with (WINDOW_H-1) line memories per channel and adds valid gating, coordinates and start-of-frame resync.

---
 rtl/stereo_window_buff_if.sv | 31 +++
 rtl/stereo_window_buff.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/stereo_window_buff_if.sv
// Pixel-in / window-out bundle for stereo_window_buff.
// master drives pixels and observes windows; slave is the window generator.
interface stereo_window_buff_if #(
  parameter int PIXEL_DEPT = 5,
  parameter int FRAME_W    = 100,
  parameter int FRAME_H    = 100,
  parameter int WINDOW_W   = 10,
  parameter int WINDOW_H   = 10,
  parameter int CH         = 2
);
  localparam int CW = $clog2(FRAME_W);
  localparam int RW = $clog2(FRAME_H);

  logic                                      in_valid;
  logic                                      in_sof;
  logic [CH*PIXEL_DEPT-1:0]                  in_data;
  logic [CH*WINDOW_H*WINDOW_W*PIXEL_DEPT-1:0] out_win;
  logic                                      out_valid;
  logic [CW-1:0]                             out_col;
  logic [RW-1:0]                             out_row;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_win, out_valid, out_col, out_row
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_win, out_valid, out_col, out_row
  );
endinterface

// File: rtl/stereo_window_buff.sv
// Line-buffer sliding-window generator for CH lock-step pixel streams.
// Define STEREO_WINDOW_BUFF_OUTREG_EN to add one output register stage (latency 2).
module stereo_window_buff #(
  parameter int PIXEL_DEPT = 5,
  parameter int FRAME_W    = 100,
  parameter int FRAME_H    = 100,
  parameter int WINDOW_W   = 10,
  parameter int WINDOW_H   = 10,
  parameter int CH         = 2
) (
  input  logic                 pclk,
  input  logic                 rst,
  stereo_window_buff_if.slave  bus
);
  localparam int CW       = $clog2(FRAME_W);
  localparam int RW       = $clog2(FRAME_H);
  localparam int NL       = WINDOW_H - 1;
  localparam int WIN_BITS = WINDOW_H * WINDOW_W * PIXEL_DEPT;

  logic                  acc;
  logic [CW-1:0]         col, col_nxt, pcol;
  logic [RW-1:0]         row, row_nxt, prow;
  logic                  pix_ok;
  logic [PIXEL_DEPT-1:0] pix     [CH];
  logic [PIXEL_DEPT-1:0] line_rd [CH][NL];

  logic [PIXEL_DEPT-1:0] line_mem [CH][NL][FRAME_W];

  logic [PIXEL_DEPT-1:0] win_p0 [CH][WINDOW_H][WINDOW_W];
  logic                  vld_p0;
  logic [CW-1:0]         col_p0;
  logic [RW-1:0]         row_p0;
  logic [CH*WIN_BITS-1:0] win_flat_p0;

  // sof pins the accepted pixel to (0,0) before anything else uses its position
  always_comb begin
    acc  = bus.in_valid;
    pcol = bus.in_sof ? '0 : col;
    prow = bus.in_sof ? '0 : row;
    if (pcol == CW'(FRAME_W - 1)) begin
      col_nxt = '0;
      row_nxt = (prow == RW'(FRAME_H - 1)) ? '0 : prow + RW'(1);
    end else begin
      col_nxt = pcol + CW'(1);
      row_nxt = prow;
    end
    pix_ok = (pcol >= CW'(WINDOW_W - 1)) && (prow >= RW'(WINDOW_H - 1));
    for (int c = 0; c < CH; c++) begin
      pix[c] = bus.in_data[c*PIXEL_DEPT +: PIXEL_DEPT];
      for (int k = 0; k < NL; k++) begin
        line_rd[c][k] = line_mem[c][k][pcol];
      end
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

  // Line memories cascade: line 0 takes the new pixel, line k takes line k-1's old value
  always_ff @(posedge pclk) begin
    if (acc) begin
      for (int c = 0; c < CH; c++) begin
        line_mem[c][0][pcol] <= pix[c];
        for (int k = 1; k < NL; k++) begin
          line_mem[c][k][pcol] <= line_rd[c][k-1];
        end
      end
    end
  end

  // ---- stage p0: window shift and output coordinates ----
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++)
        for (int r = 0; r < WINDOW_H; r++)
          for (int w = 0; w < WINDOW_W; w++)
            win_p0[c][r][w] <= '0;
      vld_p0 <= 1'b0;
      col_p0 <= '0;
      row_p0 <= '0;
    end else begin
      vld_p0 <= acc && pix_ok;
      if (acc) begin
        col_p0 <= pcol;
        row_p0 <= prow;
        for (int c = 0; c < CH; c++) begin
          for (int r = 0; r < WINDOW_H; r++)
            for (int w = 0; w < WINDOW_W - 1; w++)
              win_p0[c][r][w] <= win_p0[c][r][w+1];
          win_p0[c][WINDOW_H-1][WINDOW_W-1] <= pix[c];
          for (int k = 0; k < NL; k++)
            win_p0[c][WINDOW_H-1-k-1][WINDOW_W-1] <= line_rd[c][k];
        end
      end
    end
  end

  // Top-left (oldest) pixel lands in the MSBs, bottom-right in the LSBs
  always_comb begin
    win_flat_p0 = '0;
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < WINDOW_H; r++)
        for (int w = 0; w < WINDOW_W; w++)
          win_flat_p0[c*WIN_BITS + ((WINDOW_H-1-r)*WINDOW_W + (WINDOW_W-1-w))*PIXEL_DEPT +: PIXEL_DEPT]
            = win_p0[c][r][w];
  end

`ifdef STEREO_WINDOW_BUFF_OUTREG_EN
  logic [CH*WIN_BITS-1:0] win_p1;
  logic                   vld_p1;
  logic [CW-1:0]          col_p1;
  logic [RW-1:0]          row_p1;

  // ---- stage p1: optional output register ----
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      win_p1 <= '0;
      vld_p1 <= 1'b0;
      col_p1 <= '0;
      row_p1 <= '0;
    end else begin
      win_p1 <= win_flat_p0;
      vld_p1 <= vld_p0;
      col_p1 <= col_p0;
      row_p1 <= row_p0;
    end
  end

  assign bus.out_win   = win_p1;
  assign bus.out_valid = vld_p1;
  assign bus.out_col   = col_p1;
  assign bus.out_row   = row_p1;
`else
  assign bus.out_win   = win_flat_p0;
  assign bus.out_valid = vld_p0;
  assign bus.out_col   = col_p0;
  assign bus.out_row   = row_p0;
`endif

endmodule
